// File: rtl/multi_tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator.
// Holds the channel mode encoding, default sizing and a helper that picks
// one channel's divisor out of the packed divisor bus.
package multi_tick_gen_pkg;

    // Mode of a channel, captured on its load strobe
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Default sizing used when the top is instantiated without overrides
    localparam int unsigned DEFAULT_NCH   = 4;
    localparam int unsigned DEFAULT_WIDTH = 32;

    // Upper bounds for the slice helper: one channel may be up to
    // MAX_WIDTH bits, and the whole packed bus up to MAX_BUS_W bits
    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned MAX_BUS_W = 1024;

    // Extract channel idx (each channel width bits wide) from a packed bus.
    // The result is zero-extended to MAX_WIDTH; callers cast it to their width.
    function automatic logic [MAX_WIDTH-1:0] chan_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          width
    );
        logic [MAX_WIDTH-1:0] mask;
        if (width >= MAX_WIDTH) begin
            mask = '1;
        end else begin
            mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
        end
        chan_slice = MAX_WIDTH'(bus >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/multi_tick_gen_chan.sv
// One channel of the tick generator: a reloadable down-counter that emits a
// one-cycle tick every period_q enabled cycles, periodic or one-shot.
// Optional toggle output is built only when MULTI_TICK_GEN_SQUARE_EN is defined;
// otherwise sq_o is tied low and no toggle flop exists.
module multi_tick_gen_chan
    import multi_tick_gen_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned RESET_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             oneshot_i,
    output logic             tick_o,
    output logic             busy_o,
    output logic             sq_o
);

    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic             mode_q,   mode_d;
    logic             armed_q,  armed_d;
    logic             tick_q,   tick_d;
    logic             busy_q,   busy_d;

    // Next-state: load beats counting; reload happens at cnt==1 so the
    // counter never decrements through zero
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        armed_d  = armed_q;
        tick_d   = 1'b0;
        if (load_i) begin
            period_d = div_i;
            cnt_d    = div_i;
            mode_d   = oneshot_i;
            armed_d  = 1'b1;
        end else if (en_i && armed_q && (period_q != '0)) begin
            if (cnt_q == ONE) begin
                tick_d = 1'b1;
                cnt_d  = period_q;
                if (mode_q == MODE_ONESHOT) begin
                    armed_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end
        busy_d = armed_d & en_i & (period_d != '0);
    end

    // Channel state and registered tick/busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= RESET_VAL;
            cnt_q    <= RESET_VAL;
            mode_q   <= MODE_PERIODIC;
            armed_q  <= 1'b1;
            tick_q   <= 1'b0;
            busy_q   <= en_i & (RESET_VAL != '0);
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            armed_q  <= armed_d;
            tick_q   <= tick_d;
            busy_q   <= busy_d;
        end
    end

    assign tick_o = tick_q;
    assign busy_o = busy_q;

`ifdef MULTI_TICK_GEN_SQUARE_EN
    logic sq_q, sq_d;

    // Toggle on every tick so a periodic divisor N gives a 2N-cycle square wave
    always_comb begin
        sq_d = sq_q;
        if (load_i) begin
            sq_d = 1'b0;
        end else if (tick_d) begin
            sq_d = ~sq_q;
        end
    end

    // Toggle flop, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_o = sq_q;
`else
    assign sq_o = 1'b0;
`endif

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel tick generator top: NCH independent channels, each with its
// own runtime divisor, enable and periodic/one-shot mode.
// Optional square-wave outputs are enabled by MULTI_TICK_GEN_SQUARE_EN.
module multi_tick_gen
    import multi_tick_gen_pkg::*;
#(
    parameter int unsigned NCH       = DEFAULT_NCH,
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned RESET_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     en,
    input  logic [NCH-1:0]     load,
    input  logic [NCH*WIDTH-1:0] div_in,
    input  logic [NCH-1:0]     oneshot,
    output logic [NCH-1:0]     tick,
    output logic [NCH-1:0]     busy,
    output logic [NCH-1:0]     sq_out
);

    // The slice helper works on a fixed-size bus, so the configuration must fit it
    if ((WIDTH > MAX_WIDTH) || (NCH * WIDTH > MAX_BUS_W)) begin : g_cfg_error
        $error("multi_tick_gen: NCH*WIDTH or WIDTH exceeds package limits");
    end

    logic [MAX_BUS_W-1:0] divBus;
    assign divBus = MAX_BUS_W'(div_in);

    // One channel instance per bit of the control vectors
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic [WIDTH-1:0] chanDiv;
        assign chanDiv = WIDTH'(chan_slice(divBus, i, WIDTH));

        multi_tick_gen_chan #(
            .WIDTH     (WIDTH),
            .RESET_DIV (RESET_DIV)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en_i      (en[i]),
            .load_i    (load[i]),
            .div_i     (chanDiv),
            .oneshot_i (oneshot[i]),
            .tick_o    (tick[i]),
            .busy_o    (busy[i]),
            .sq_o      (sq_out[i])
        );
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen (NCH=4, WIDTH=8, RESET_DIV=1).
// A table of per-cycle vectors exercises periodic, one-shot, enable-freeze,
// load-on-reload and divisor-zero cases; hand sequences cover reset and sq_out.
module tb_multi_tick_gen;

    localparam int NCH   = 4;
    localparam int WIDTH = 8;

    logic                 clk;
    logic                 rst;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       load;
    logic [NCH*WIDTH-1:0] div_in;
    logic [NCH-1:0]       oneshot;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       sq_out;

    int checks   = 0;
    int failures = 0;

    multi_tick_gen #(
        .NCH       (NCH),
        .WIDTH     (WIDTH),
        .RESET_DIV (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
        .oneshot (oneshot),
        .tick    (tick),
        .busy    (busy),
        .sq_out  (sq_out)
    );

    // 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  load;
        logic [3:0]  oneshot;
        logic [31:0] divBus;
        logic [3:0]  expTick;
        logic [3:0]  expBusy;
    } vec_t;

    vec_t vecs[$];

    // Append one vector; divisors are given per channel as d3..d0
    task automatic addVec(input logic [3:0] e, input logic [3:0] l, input logic [3:0] o,
                          input logic [7:0] d3, input logic [7:0] d2,
                          input logic [7:0] d1, input logic [7:0] d0,
                          input logic [3:0] t, input logic [3:0] b);
        vec_t v;
        v.en      = e;
        v.load    = l;
        v.oneshot = o;
        v.divBus  = {d3, d2, d1, d0};
        v.expTick = t;
        v.expBusy = b;
        vecs.push_back(v);
    endtask

    // Drive inputs for one edge, then wait until just after that edge
    task automatic applyStimulus(input logic r, input logic [3:0] e, input logic [3:0] l,
                                 input logic [3:0] o, input logic [31:0] d);
        rst     = r;
        en      = e;
        load    = l;
        oneshot = o;
        div_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s[%0d] got=%b expected=%b", name, idx, act, exp);
        end
    endtask

    logic expSq;

    initial begin
        rst = 1'b1; en = 4'hF; load = '0; oneshot = '0; div_in = '0;

        // Scenario A: ch0 periodic N=5, others keep ticking at RESET_DIV=1
        addVec(4'hF, 4'h1, 4'h0, 8'd0, 8'd0, 8'd0, 8'd5, 4'hE, 4'hF);
        for (int k = 0; k < 4; k++) addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hE, 4'hF);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hF, 4'hF);
        for (int k = 0; k < 4; k++) addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hE, 4'hF);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hF, 4'hF);
        // Scenario B: ch0 back to N=1, ch1 one-shot N=3, then re-armed
        addVec(4'hF, 4'h3, 4'h2, 8'd0, 8'd0, 8'd3, 8'd1, 4'hC, 4'hF);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hD, 4'hF);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hD, 4'hF);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hF, 4'hD);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hD, 4'hD);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hD, 4'hD);
        addVec(4'hF, 4'h2, 4'h2, 8'd0, 8'd0, 8'd3, 8'd0, 4'hD, 4'hF);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hD, 4'hF);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hD, 4'hF);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hF, 4'hD);
        // Scenario C: ch2 N=4, two counted cycles, 7 cycles frozen, then resume
        addVec(4'hF, 4'h4, 4'h0, 8'd0, 8'd4, 8'd0, 8'd0, 4'h9, 4'hD);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'h9, 4'hD);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'h9, 4'hD);
        for (int k = 0; k < 7; k++) addVec(4'hB, 4'h0, 4'h0, 0, 0, 0, 0, 4'h9, 4'h9);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'h9, 4'hD);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hD, 4'hD);
        // Scenario D: reload ch2 with N=2 on the edge where cnt==1
        for (int k = 0; k < 3; k++) addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'h9, 4'hD);
        addVec(4'hF, 4'h4, 4'h0, 8'd0, 8'd2, 8'd0, 8'd0, 4'h9, 4'hD);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'h9, 4'hD);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'hD, 4'hD);
        // Scenario E: ch3 loaded with divisor 0 goes idle
        addVec(4'hF, 4'h8, 4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'h1, 4'h5);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'h5, 4'h5);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'h1, 4'h5);
        addVec(4'hF, 4'h0, 4'h0, 0, 0, 0, 0, 4'h5, 4'h5);

        // Reset state
        applyStimulus(1'b1, 4'hF, 4'h0, 4'h0, '0);
        applyStimulus(1'b1, 4'hF, 4'h0, 4'h0, '0);
        checkOutput("reset_tick", 0, tick, 4'h0);
        checkOutput("reset_busy", 0, busy, 4'hF);
        checkOutput("reset_sq", 0, sq_out, 4'h0);

        // RESET_DIV=1: tick every cycle from the first edge after reset
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'hF, 4'h0, 4'h0, '0);
            checkOutput("free_tick", k, tick, 4'hF);
            checkOutput("free_busy", k, busy, 4'hF);
        end

        foreach (vecs[k]) begin
            applyStimulus(1'b0, vecs[k].en, vecs[k].load, vecs[k].oneshot, vecs[k].divBus);
            checkOutput("vec_tick", k, tick, vecs[k].expTick);
            checkOutput("vec_busy", k, busy, vecs[k].expBusy);
        end

        // Reset mid-count: busy follows en during reset, progress is discarded
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, '0);
        checkOutput("rst_en0_busy", 0, busy, 4'h0);
        checkOutput("rst_en0_tick", 0, tick, 4'h0);
        applyStimulus(1'b1, 4'hF, 4'h0, 4'h0, '0);
        checkOutput("rst_en1_busy", 0, busy, 4'hF);
        applyStimulus(1'b0, 4'hF, 4'h0, 4'h0, '0);
        checkOutput("post_rst_tick", 0, tick, 4'hF);

        // Square wave on ch0 with N=3: toggles on every third edge after load
        applyStimulus(1'b0, 4'hF, 4'h1, 4'h0, 32'h0000_0003);
        checkOutput("sq_load", 0, {3'b000, sq_out[0]}, 4'h0);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, 4'hF, 4'h0, 4'h0, '0);
`ifdef MULTI_TICK_GEN_SQUARE_EN
            expSq = ((k / 3) % 2) == 1;
`else
            expSq = 1'b0;
`endif
            checkOutput("sq_tick", k, {3'b000, tick[0]}, {3'b000, (k % 3) == 0});
            checkOutput("sq_out", k, {3'b000, sq_out[0]}, {3'b000, expSq});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
